// File: rtl/adder_seq_ctrl.sv
// Multi-cycle sequencer driving a shared 6-bit adder for ADD/SUB/INC/MUL.
// Results and flags are returned through a valid/ready handshake.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a request; adder operands zero
// EXEC1 | first adder pass (ADD/INC result, or SUB a + ~b)
// EXEC2 | SUB second pass: tmp + 1
// MULI  | shift-and-add iterations i = 0..5
// DONE  | out_valid pulse, back to IDLE
module adder_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] op,
  input  logic [5:0] a,
  input  logic [5:0] b,
  output logic [5:0] add_a,
  output logic [5:0] add_b,
  input  logic [5:0] add_r,
  input  logic       add_cf,
  output logic       out_valid,
  output logic [5:0] r,
  output logic       cf,
  output logic       sf,
  output logic       zf
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXEC1 = 3'd1,
    S_EXEC2 = 3'd2,
    S_MULI  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] op_q;
  logic [5:0] a_q, b_q;
  logic [5:0] tmp, acc;
  logic       c1, ov;
  logic [2:0] cnt;

  logic       accept;
  logic       mul_bit;
  logic [5:0] a_shl;
  logic [5:0] a_lost;
  logic [5:0] acc_nxt;
  logic       ov_nxt;

  assign accept  = in_valid & in_ready;
  assign mul_bit = b_q[cnt];
  assign a_shl   = a_q << cnt;
  // Bits of a pushed past bit 5 by the shift; any of them set means overflow.
  assign a_lost  = a_q >> (3'd6 - cnt);
  assign acc_nxt = mul_bit ? add_r : acc;
  assign ov_nxt  = ov | (mul_bit & (add_cf | (|a_lost)));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = (op == OP_MUL) ? S_MULI : S_EXEC1;
      S_EXEC1: state_nxt = (op_q == OP_SUB) ? S_EXEC2 : S_DONE;
      S_EXEC2: state_nxt = S_DONE;
      S_MULI:  if (cnt == 3'd5) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = 6'd0;
    add_b     = 6'd0;
    case (state)
      S_IDLE:  in_ready = 1'b1;
      S_EXEC1: begin
        add_a = a_q;
        case (op_q)
          OP_SUB:  add_b = ~b_q;
          OP_INC:  add_b = 6'd1;
          default: add_b = b_q;
        endcase
      end
      S_EXEC2: begin
        add_a = tmp;
        add_b = 6'd1;
      end
      S_MULI: begin
        add_a = acc;
        add_b = mul_bit ? a_shl : 6'd0;
      end
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= OP_ADD;
      a_q  <= 6'd0;
      b_q  <= 6'd0;
      tmp  <= 6'd0;
      c1   <= 1'b0;
      acc  <= 6'd0;
      ov   <= 1'b0;
      cnt  <= 3'd0;
      r    <= 6'd0;
      cf   <= 1'b0;
      sf   <= 1'b0;
      zf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_q <= op;
          a_q  <= a;
          b_q  <= b;
          acc  <= 6'd0;
          ov   <= 1'b0;
          cnt  <= 3'd0;
        end
        S_EXEC1: begin
          if (op_q == OP_SUB) begin
            tmp <= add_r;
            c1  <= add_cf;
          end else begin
            r  <= add_r;
            cf <= add_cf;
            sf <= add_r[5];
            zf <= (add_r == 6'd0);
          end
        end
        S_EXEC2: begin
          r  <= add_r;
          cf <= c1 | add_cf;
          sf <= add_r[5];
          zf <= (add_r == 6'd0);
        end
        S_MULI: begin
          acc <= acc_nxt;
          ov  <= ov_nxt;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd5) begin
            r  <= acc_nxt;
            cf <= ov_nxt;
            sf <= acc_nxt[5];
            zf <= (acc_nxt == 6'd0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl; the shared adder is modelled as a plain
// 6-bit combinational sum with carry-out.
module tb_adder_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op;
  logic [5:0] a, b;
  logic [5:0] add_a, add_b, add_r;
  logic       add_cf;
  logic       out_valid;
  logic [5:0] r;
  logic       cf, sf, zf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign {add_cf, add_r} = {1'b0, add_a} + {1'b0, add_b};

  adder_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .add_a(add_a), .add_b(add_b),
    .add_r(add_r), .add_cf(add_cf), .out_valid(out_valid),
    .r(r), .cf(cf), .sf(sf), .zf(zf)
  );

  // Issue one request from IDLE and report latency, result, flags and whether
  // out_valid dropped again the cycle after its pulse.
  task automatic run_op(input logic [1:0] o, input logic [5:0] x, input logic [5:0] y,
                        output int lat, output logic [8:0] res, output logic pulse_ok);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    res = 9'h1ff;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        res = {r, cf, sf, zf};
        break;
      end
    end
    @(negedge clk);
    pulse_ok = !out_valid && ({r, cf, sf, zf} === res);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; op = 2'b00; a = 6'd0; b = 6'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, r, cf, sf, zf, add_a, add_b} !== {1'b1, 1'b0, 21'd0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b ov=%b r=%0d cf=%b sf=%b zf=%b aa=%0d ab=%0d, want rdy=1 ov=0 all else 0",
               in_ready, out_valid, r, cf, sf, zf, add_a, add_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_add;
    int lat; logic [8:0] res; logic pok;
    run_op(2'b00, 6'd5, 6'd7, lat, res, pok);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d want 2", lat); end
    checks++;
    if (res !== {6'd12, 3'b000}) begin errors++; $display("FAIL add_5_7: got r=%0d f=%b want r=12 f=000", res[8:3], res[2:0]); end
    checks++;
    if (pok !== 1'b1) begin errors++; $display("FAIL add_pulse_hold: got %b want 1", pok); end
    run_op(2'b00, 6'd63, 6'd1, lat, res, pok);
    checks++;
    if (res !== {6'd0, 3'b101}) begin errors++; $display("FAIL add_63_1: got r=%0d f=%b want r=0 f=101", res[8:3], res[2:0]); end
  endtask

  task automatic test_sub;
    int lat; logic [8:0] res; logic pok;
    run_op(2'b01, 6'd5, 6'd7, lat, res, pok);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL sub_latency: got %0d want 3", lat); end
    checks++;
    if (res !== {6'd62, 3'b010}) begin errors++; $display("FAIL sub_5_7: got r=%0d f=%b want r=62 f=010", res[8:3], res[2:0]); end
    run_op(2'b01, 6'd7, 6'd7, lat, res, pok);
    checks++;
    if (res !== {6'd0, 3'b101}) begin errors++; $display("FAIL sub_7_7: got r=%0d f=%b want r=0 f=101", res[8:3], res[2:0]); end
    run_op(2'b01, 6'd20, 6'd0, lat, res, pok);
    checks++;
    if (res !== {6'd20, 3'b100}) begin errors++; $display("FAIL sub_20_0: got r=%0d f=%b want r=20 f=100", res[8:3], res[2:0]); end
  endtask

  task automatic test_inc;
    int lat; logic [8:0] res; logic pok;
    run_op(2'b10, 6'd63, 6'd42, lat, res, pok);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL inc_latency: got %0d want 2", lat); end
    checks++;
    if (res !== {6'd0, 3'b101}) begin errors++; $display("FAIL inc_63: got r=%0d f=%b want r=0 f=101", res[8:3], res[2:0]); end
    run_op(2'b10, 6'd30, 6'd42, lat, res, pok);
    checks++;
    if (res !== {6'd31, 3'b000}) begin errors++; $display("FAIL inc_30: got r=%0d f=%b want r=31 f=000", res[8:3], res[2:0]); end
  endtask

  task automatic test_mul;
    int lat; logic [8:0] res; logic pok;
    run_op(2'b11, 6'd7, 6'd9, lat, res, pok);
    checks++;
    if (lat !== 7) begin errors++; $display("FAIL mul_latency: got %0d want 7", lat); end
    checks++;
    if (res !== {6'd63, 3'b010}) begin errors++; $display("FAIL mul_7_9: got r=%0d f=%b want r=63 f=010", res[8:3], res[2:0]); end
    checks++;
    if (pok !== 1'b1) begin errors++; $display("FAIL mul_pulse_hold: got %b want 1", pok); end
    run_op(2'b11, 6'd8, 6'd8, lat, res, pok);
    checks++;
    if (res !== {6'd0, 3'b101}) begin errors++; $display("FAIL mul_8_8: got r=%0d f=%b want r=0 f=101", res[8:3], res[2:0]); end
    run_op(2'b11, 6'd0, 6'd63, lat, res, pok);
    checks++;
    if (lat !== 7 || res !== {6'd0, 3'b001}) begin errors++; $display("FAIL mul_0_63: got lat=%0d r=%0d f=%b want lat=7 r=0 f=001", lat, res[8:3], res[2:0]); end
    run_op(2'b11, 6'd5, 6'd6, lat, res, pok);
    checks++;
    if (res !== {6'd30, 3'b000}) begin errors++; $display("FAIL mul_5_6: got r=%0d f=%b want r=30 f=000", res[8:3], res[2:0]); end
    // 9*7 = 63 via adds that never carry; 33*2 overflows only through a shifted-out bit
    run_op(2'b11, 6'd33, 6'd2, lat, res, pok);
    checks++;
    if (res !== {6'd2, 3'b100}) begin errors++; $display("FAIL mul_33_2: got r=%0d f=%b want r=2 f=100", res[8:3], res[2:0]); end
  endtask

  task automatic test_back_to_back;
    int rdy_k, ov1_k, ov2_k;
    logic [5:0] r1, r2, rmid;
    logic hold_ok;
    rdy_k = -1; ov1_k = -1; ov2_k = -1; r1 = 6'h3f; r2 = 6'h3f; hold_ok = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; op = 2'b11; a = 6'd7; b = 6'd9;
    @(posedge clk);
    #1 op = 2'b00; a = 6'd1; b = 6'd1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (out_valid && ov1_k < 0) begin ov1_k = k; r1 = r; end
      else if (out_valid) begin ov2_k = k; r2 = r; end
      else if (ov1_k > 0 && ov2_k < 0 && r !== r1) hold_ok = 1'b0;
      if (in_ready && rdy_k < 0) rdy_k = k;
      if (k == rdy_k) begin @(posedge clk); #1 in_valid = 1'b0; end
    end
    rmid = r1;
    checks++;
    if (rdy_k !== 8) begin errors++; $display("FAIL b2b_accept_gap: got %0d want 8", rdy_k); end
    checks++;
    if (ov1_k !== 7 || rmid !== 6'd63) begin errors++; $display("FAIL b2b_first: got k=%0d r=%0d want k=7 r=63", ov1_k, rmid); end
    checks++;
    if (ov2_k !== 10 || r2 !== 6'd2) begin errors++; $display("FAIL b2b_second: got k=%0d r=%0d want k=10 r=2", ov2_k, r2); end
    checks++;
    if (hold_ok !== 1'b1) begin errors++; $display("FAIL b2b_flag_hold: got %b want 1", hold_ok); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    int lat; logic [8:0] res; logic pok; logic saw_ov;
    @(negedge clk);
    in_valid = 1'b1; op = 2'b11; a = 6'd7; b = 6'd9;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, r, cf, sf, zf} !== {1'b1, 1'b0, 9'd0}) begin
      errors++;
      $display("FAIL reset_mid_state: got rdy=%b ov=%b r=%0d f=%b%b%b want rdy=1 ov=0 r=0 f=000",
               in_ready, out_valid, r, cf, sf, zf);
    end
    rst = 1'b0;
    saw_ov = 1'b0;
    repeat (8) begin @(negedge clk); if (out_valid) saw_ov = 1'b1; end
    checks++;
    if (saw_ov !== 1'b0) begin errors++; $display("FAIL reset_mid_no_pulse: got %b want 0", saw_ov); end
    run_op(2'b00, 6'd1, 6'd2, lat, res, pok);
    checks++;
    if (lat !== 2 || res !== {6'd3, 3'b000}) begin errors++; $display("FAIL reset_then_add: got lat=%0d r=%0d f=%b want lat=2 r=3 f=000", lat, res[8:3], res[2:0]); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_inc;
    test_mul;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
